// File: rtl/hex_disp_arb_pkg.sv
// Shared types and constants for the hex display arbiter.
// Holds the FSM state enum, requester count and default idle value.
package hex_disp_pkg;
  localparam int NREQ = 4;
  localparam logic [31:0] IDLE_DATA_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_OWN
  } state_e;

  function automatic logic [1:0] oh2idx(input logic [NREQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/hex_disp_arb_if.sv
// Requester/display bundle of the hex display arbiter.
// master: requesters and display consumer side; slave: the arbiter.
interface hex_disp_arb_if;
  import hex_disp_pkg::*;

  logic [NREQ-1:0]    req;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    grant;
  logic [31:0]        disp_data;
  logic               disp_en;
  logic               busy;

  modport master (output req, req_data, input grant, disp_data, disp_en, busy);
  modport slave  (input req, req_data, output grant, disp_data, disp_en, busy);
endinterface

// File: rtl/hex_disp_arb_rr_pick.sv
// Combinational round-robin picker: searches upward from last+1, wrapping,
// skipping any requester set in the exclude mask.
module rr_pick
  import hex_disp_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      last_i,
  input  logic [NREQ-1:0] excl_i,
  output logic [NREQ-1:0] win_o,
  output logic            vld_o
);
  logic [NREQ-1:0] cand;
  logic [1:0]      idx;

  always_comb begin
    cand  = req_i & ~excl_i;
    win_o = '0;
    vld_o = 1'b0;
    idx   = '0;
    // k wraps to 0 on the last step, so last_i itself is tried last
    for (int k = 1; k <= NREQ; k++) begin
      idx = last_i + 2'(k);
      if (!vld_o && cand[idx]) begin
        win_o[idx] = 1'b1;
        vld_o      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/hex_disp_arb.sv
// Time-sharing arbiter for the 8-digit hex display: minimum dwell, then round-robin.
// Define HEX_ARB_BLANK_EN to blank the display (disp_en=0) while idle.
module hex_disp_arb
  import hex_disp_pkg::*;
#(
  parameter int unsigned HOLD_CYC  = 50_000_000,
  parameter logic [31:0] IDLE_DATA = IDLE_DATA_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  hex_disp_arb_if.slave  bus
);
  localparam int CNT_W = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);

  state_e           state_q;
  logic [1:0]       last_q;
  logic [CNT_W-1:0] cnt_q;
  logic [NREQ-1:0]  grant_q;
  logic [31:0]      disp_q;
  logic             busy_q;

  logic [NREQ-1:0]  win;
  logic             win_vld;
  logic [1:0]       win_idx;
  logic             owner_req;
  logic [31:0]      owner_data;
  logic [31:0]      win_data;
  logic             grant_d, idle_d, own_d;

  // The current owner is always the excluded one, so the same picker serves IDLE
  rr_pick u_pick (
    .req_i  (bus.req),
    .last_i (last_q),
    .excl_i (grant_q),
    .win_o  (win),
    .vld_o  (win_vld)
  );

  assign win_idx    = oh2idx(win);
  assign owner_req  = |(bus.req & grant_q);
  assign owner_data = bus.req_data[32*last_q +: 32];
  assign win_data   = bus.req_data[32*win_idx +: 32];

  always_comb begin
    grant_d = 1'b0;
    idle_d  = 1'b0;
    own_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: grant_d = win_vld;
      ST_HOLD: begin
        if (cnt_q == '0) begin
          grant_d = win_vld;
          own_d   = !win_vld && owner_req;
          idle_d  = !win_vld && !owner_req;
        end
      end
      ST_OWN: begin
        grant_d = win_vld;
        idle_d  = !win_vld && !owner_req;
      end
      default: idle_d = 1'b1;
    endcase
  end

`ifdef HEX_ARB_BLANK_EN
  logic en_q;
  assign bus.disp_en = en_q;
`else
  assign bus.disp_en = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      grant_q <= '0;
      disp_q  <= IDLE_DATA;
      busy_q  <= 1'b0;
`ifdef HEX_ARB_BLANK_EN
      en_q    <= 1'b0;
`endif
    end else begin
      if (grant_d) begin
        state_q <= ST_HOLD;
        grant_q <= win;
        last_q  <= win_idx;
        cnt_q   <= CNT_LOAD;
        disp_q  <= win_data;
        busy_q  <= 1'b1;
      end else if (idle_d) begin
        state_q <= ST_IDLE;
        grant_q <= '0;
        disp_q  <= IDLE_DATA;
        busy_q  <= 1'b0;
      end else begin
        if (own_d) state_q <= ST_OWN;
        if (state_q == ST_HOLD && cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        // An owner with req low leaves the display frozen
        if (state_q != ST_IDLE && owner_req) disp_q <= owner_data;
      end
`ifdef HEX_ARB_BLANK_EN
      if (grant_d)     en_q <= 1'b1;
      else if (idle_d) en_q <= 1'b0;
`endif
    end
  end

  assign bus.grant     = grant_q;
  assign bus.disp_data = disp_q;
  assign bus.busy      = busy_q;
endmodule
